// File: rtl/stream_demux_pkg.sv
// stream_demux shared types.
// Holds the packet FSM encoding and the select range helper.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    DROP
  } demux_state_t;

  function automatic logic sel_in_range(
    input int unsigned sel,
    input int unsigned n
  );
    return sel < n;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice.
// free tells the producer a load this cycle cannot overwrite live data.
module stream_reg_slice #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         free
);

  assign free = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1-to-N stream demultiplexer.
// Destination is latched on the first beat and held to the last.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N_OUT = 4,
  parameter  int CNT_W = 16,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_last,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N_OUT-1:0][WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]            out_last,
  output logic [N_OUT-1:0]            out_valid,
  input  logic [N_OUT-1:0]            out_ready,
  output logic                        err_sel,
  output logic [CNT_W-1:0]            drop_cnt
);

  demux_state_t     state;
  demux_state_t     state_nxt;
  logic [SEL_W-1:0] cur_sel;
  logic [SEL_W-1:0] cur_sel_nxt;
  logic [SEL_W-1:0] tgt;
  logic             sel_ok;
  logic             tgt_free;
  logic             acc;
  logic             fwd;
  logic             bad;
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] free;

  assign sel_ok = sel_in_range(32'(in_sel), N_OUT);
  assign tgt    = (state == IDLE) ? in_sel : cur_sel;
  assign acc    = in_valid && in_ready;

  // Loop match avoids indexing free[] with an out-of-range select
  always_comb begin
    tgt_free = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (tgt == SEL_W'(k)) tgt_free = free[k];
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      unique case (state)
        IDLE:    in_ready = sel_ok ? tgt_free : 1'b1;
        ROUTE:   in_ready = tgt_free;
        DROP:    in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    cur_sel_nxt = cur_sel;
    fwd         = 1'b0;
    bad         = 1'b0;
    if (acc) begin
      unique case (state)
        IDLE: begin
          if (!sel_ok) begin
            bad = 1'b1;
            if (!in_last) state_nxt = DROP;
          end else begin
            fwd = 1'b1;
            if (!in_last) begin
              state_nxt   = ROUTE;
              cur_sel_nxt = in_sel;
            end
          end
        end
        ROUTE: begin
          fwd = 1'b1;
          if (in_last) state_nxt = IDLE;
        end
        DROP: begin
          if (in_last) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_sel  <= '0;
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cur_sel <= cur_sel_nxt;
      err_sel <= bad;
      if (bad && drop_cnt != {CNT_W{1'b1}})
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    logic [WIDTH:0] q;

    assign load[k] = fwd && (tgt == SEL_W'(k));

    stream_reg_slice #(
      .W(WIDTH + 1)
    ) u_slice (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load[k]),
      .din  ({in_last, in_data}),
      .ready(out_ready[k]),
      .valid(out_valid[k]),
      .dout (q),
      .free (free[k])
    );

    assign out_last[k] = q[WIDTH];
    assign out_data[k] = q[WIDTH-1:0];
  end

endmodule
